// File: rtl/noc_pkg.sv
// Shared NoC types, packet field positions and hop helpers.
package noc_pkg;

  localparam int WIDTH_packet  = 57;
  localparam int WIDTH_payload = 40;

  localparam int Y_HOP_LSB = 40;
  localparam int Y_HOP_W   = 2;
  localparam int X_HOP_LSB = 42;
  localparam int X_HOP_W   = 3;
  localparam int Y_DIR_BIT = 45;
  localparam int X_DIR_BIT = 46;

  typedef enum logic [2:0] {
    PORT_N  = 3'd0,
    PORT_S  = 3'd1,
    PORT_E  = 3'd2,
    PORT_W  = 3'd3,
    PORT_PE = 3'd4
  } port_e;

  // Saturating decrement: a zero hop count stays zero.
  function automatic logic [2:0] hop_dec(input logic [2:0] h);
    return (h == 3'd0) ? 3'd0 : h - 3'd1;
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Requester and downstream link bundle for one router output port.
interface noc_output_arbiter_if #(
  parameter int WIDTH_packet = 57,
  parameter int DEPTH        = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]                in_valid;
  logic [4*WIDTH_packet-1:0] in_data;
  logic [3:0]                in_ready;
  logic                      out_valid;
  logic [WIDTH_packet-1:0]   out_data;
  logic                      out_ready;
  logic [CW-1:0]             fifo_count;
  logic                      hop_err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output fifo_count, hop_err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  fifo_count, hop_err
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin priority rotate, purely combinational.
module rr_arbiter4 (
  input  logic [3:0] valid_i,
  input  logic [1:0] last_i,
  output logic [3:0] grant_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [1:0] c;
  logic       found;

  always_comb begin
    grant_o = '0;
    idx_o   = last_i;
    found   = 1'b0;
    c       = last_i;
    for (int k = 1; k <= 4; k++) begin
      c = last_i + 2'(k);
      if (!found && valid_i[c]) begin
        found = 1'b1;
        idx_o = c;
      end
    end
    if (found) grant_o[idx_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port controller: round-robin grant, hop update, packet FIFO.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int WIDTH_packet = 57,
  parameter int DEPTH        = 2,
  parameter int PORT         = 0
) (
  input logic                 clk,
  input logic                 rst,
  noc_output_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH_packet-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              last_q;
  logic                    err_q;

  logic [3:0]              gnt;
  logic [1:0]              gidx;
  logic                    any;
  logic                    allow, push, pop;
  logic [WIDTH_packet-1:0] raw, adj;
  logic [2:0]              hv;
  logic                    under;

  rr_arbiter4 u_arb (
    .valid_i (bus.in_valid),
    .last_i  (last_q),
    .grant_o (gnt),
    .idx_o   (gidx),
    .any_o   (any)
  );

  assign allow = !rst && (cnt_q < CW'(DEPTH));
  assign push  = allow && any;
  assign pop   = (cnt_q != '0) && bus.out_ready;

  assign bus.in_ready = allow ? gnt : 4'b0000;

  always_comb begin
    raw   = bus.in_data[gidx*WIDTH_packet +: WIDTH_packet];
    adj   = raw;
    under = 1'b0;
    hv    = 3'd0;
    if (PORT == int'(PORT_N) || PORT == int'(PORT_S)) begin
      hv    = hop_dec({1'b0, raw[Y_HOP_LSB +: Y_HOP_W]});
      under = (raw[Y_HOP_LSB +: Y_HOP_W] == '0);
      adj[Y_HOP_LSB +: Y_HOP_W] = hv[1:0];
    end else if (PORT == int'(PORT_E) || PORT == int'(PORT_W)) begin
      hv    = hop_dec(raw[X_HOP_LSB +: X_HOP_W]);
      under = (raw[X_HOP_LSB +: X_HOP_W] == '0);
      adj[X_HOP_LSB +: X_HOP_W] = hv;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= 2'd3;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_q   <= wr_q + AW'(1);
        last_q <= gidx;
        err_q  <= err_q | under;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= adj;
  end

  assign bus.out_valid  = (cnt_q != '0);
  assign bus.out_data   = mem_q[rd_q];
  assign bus.fifo_count = cnt_q;
  assign bus.hop_err    = err_q;

endmodule
